// File: rtl/add_share_arb.sv
// add_share_arb: round-robin arbiter that shares one registered W-bit adder among N requesters
// and returns id-tagged sums through a credit-protected result FIFO. Option: ADD_SHARE_ARB_PRIO0_EN.
module add_share_arb #(
  parameter int W     = 8,
  parameter int N     = 4,
  parameter int LAT   = 2,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic [N*W-1:0]       req_a,
  input  logic [N*W-1:0]       req_b,
  output logic [N-1:0]         gnt,
  output logic                 add_start,
  output logic [W-1:0]         add_a,
  output logic [W-1:0]         add_b,
  input  logic [W-1:0]         add_y,
  output logic                 rsp_valid,
  output logic [$clog2(N)-1:0] rsp_id,
  output logic [W-1:0]         rsp_y,
  input  logic                 rsp_ready,
  output logic                 busy
);
  localparam int IW = $clog2(N);
  // Tag lives from the accept edge until the edge that captures add_y (LAT+2 edges later).
  localparam int NS = LAT + 2;
  localparam int CW = $clog2(DEPTH + NS + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef ADD_SHARE_ARB_PRIO0_EN
  localparam bit PRIO0 = 1'b1;
`else
  localparam bit PRIO0 = 1'b0;
`endif

  logic [IW-1:0] ptr;
  logic [IW-1:0] sel;
  logic [IW-1:0] cand;
  logic          hit;
  logic          issue_ok;
  logic [NS-1:0] tag_v;
  logic [IW-1:0] tag_id [NS];
  logic [CW-1:0] inflight;
  logic [CW-1:0] fifo_count;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [IW-1:0] fifo_id [DEPTH];
  logic [W-1:0]  fifo_y [DEPTH];
  logic          push;
  logic          pop;

  always_comb begin
    inflight = '0;
    for (int s = 0; s < NS; s++) inflight = inflight + CW'(tag_v[s]);
  end

  // Every in-flight tag already owns a FIFO slot, so the FIFO can never overflow.
  assign issue_ok = rst_n && ((fifo_count + inflight) < CW'(DEPTH));

  always_comb begin
    hit  = 1'b0;
    sel  = '0;
    cand = '0;
    gnt  = '0;
    if (issue_ok) begin
      if (PRIO0 && req[0]) hit = 1'b1;
      for (int k = 0; k < N; k++) begin
        cand = IW'((int'(ptr) + k) % N);
        if (!hit && req[cand] && !(PRIO0 && cand == '0)) begin
          hit = 1'b1;
          sel = cand;
        end
      end
      if (hit) gnt[sel] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (hit && !(PRIO0 && sel == '0)) begin
      ptr <= (int'(sel) == N - 1) ? '0 : sel + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_start <= 1'b0;
      add_a     <= '0;
      add_b     <= '0;
    end else begin
      add_start <= hit;
      if (hit) begin
        add_a <= req_a[sel*W +: W];
        add_b <= req_b[sel*W +: W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v <= '0;
      for (int s = 0; s < NS; s++) tag_id[s] <= '0;
    end else begin
      tag_v     <= {tag_v[NS-2:0], hit};
      tag_id[0] <= sel;
      for (int s = 1; s < NS; s++) tag_id[s] <= tag_id[s-1];
    end
  end

  assign push = tag_v[NS-1];
  assign pop  = rsp_valid && rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      if (push && !pop)      fifo_count <= fifo_count + CW'(1);
      else if (pop && !push) fifo_count <= fifo_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_id[wr_ptr] <= tag_id[NS-1];
      fifo_y[wr_ptr]  <= add_y;
    end
  end

  assign rsp_valid = (fifo_count != '0);
  assign rsp_id    = rsp_valid ? fifo_id[rd_ptr] : '0;
  assign rsp_y     = rsp_valid ? fifo_y[rd_ptr] : '0;
  assign busy      = (|tag_v) || rsp_valid;

endmodule

// File: tb/tb_add_share_arb.sv
// Bench for add_share_arb: directed cases plus randomized traffic checked against a
// time-stamped queue model of grants, in-flight operations and the result FIFO.
module tb_add_share_arb;
  localparam int W     = 8;
  localparam int N     = 4;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;
`ifdef ADD_SHARE_ARB_PRIO0_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  logic [N-1:0]         req;
  logic [N*W-1:0]       req_a;
  logic [N*W-1:0]       req_b;
  logic [N-1:0]         gnt;
  logic                 add_start;
  logic [W-1:0]         add_a;
  logic [W-1:0]         add_b;
  logic [W-1:0]         add_y;
  logic                 rsp_valid;
  logic [$clog2(N)-1:0] rsp_id;
  logic [W-1:0]         rsp_y;
  logic                 rsp_ready;
  logic                 busy;

  add_share_arb #(.W(W), .N(N), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_a(req_a), .req_b(req_b), .gnt(gnt),
    .add_start(add_start), .add_a(add_a), .add_b(add_b), .add_y(add_y),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_y(rsp_y), .rsp_ready(rsp_ready),
    .busy(busy)
  );

  // Adder: samples start/a/b on an edge, y updates LAT edges later; junk when no start.
  logic [W-1:0] sy [LAT+1];
  always @(posedge clk) begin
    sy[0] <= add_start ? W'(add_a + add_b) : W'($urandom);
    for (int k = 1; k <= LAT; k++) sy[k] <= sy[k-1];
  end
  assign add_y = sy[LAT];

  typedef struct { int id; logic [W-1:0] y; int due; } op_t;
  op_t m_infl[$];
  op_t m_fifo[$];
  int  m_ptr;
  int  m_cyc;
  bit  m_start;
  int  n_chk;
  int  n_pass;
  int  ovf;
  int  last_pick;
  logic [N-1:0] s_gnt;
  logic         s_valid;
  logic         s_busy;
  logic [$clog2(N)-1:0] s_id;
  logic [W-1:0] s_y;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int model_pick(input logic [N-1:0] r, input int p);
    if (PRIO && r[0]) return 0;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (p + k) % N;
      if (r[c] && !(PRIO && c == 0)) return c;
    end
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v[k]) return k;
    return -1;
  endfunction

  function automatic logic [W-1:0] rnd_op();
    return ($urandom_range(0, 3) == 0) ? {W{1'b1}} : W'($urandom);
  endfunction

  task automatic model_reset();
    m_infl.delete();
    m_fifo.delete();
    m_ptr = 0;
    m_start = 1'b0;
    last_pick = -1;
  endtask

  // One clock: check outputs at the falling edge, then advance the model across the rising edge.
  task automatic cycle();
    int pick;
    bit pop;
    logic [N-1:0] exp_gnt;
    logic [W-1:0] sum;
    @(negedge clk);
    pick = (m_fifo.size() + m_infl.size() < DEPTH) ? model_pick(req, m_ptr) : -1;
    exp_gnt = (pick >= 0) ? N'(1 << pick) : '0;
    s_gnt = gnt; s_valid = rsp_valid; s_busy = busy; s_id = rsp_id; s_y = rsp_y;
    chk("gnt", 32'(gnt), 32'(exp_gnt));
    chk("add_start", 32'(add_start), 32'(m_start));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_fifo.size() != 0));
    if (m_fifo.size() != 0) begin
      chk("rsp_id", 32'(rsp_id), 32'(m_fifo[0].id));
      chk("rsp_y", 32'(rsp_y), 32'(m_fifo[0].y));
    end
    chk("busy", 32'(busy), 32'((m_fifo.size() + m_infl.size()) != 0));
    if (dut.push && !dut.pop && int'(dut.fifo_count) == DEPTH) ovf++;
    pop = (m_fifo.size() != 0) && rsp_ready;
    sum = (pick >= 0) ? W'(req_a[pick*W +: W] + req_b[pick*W +: W]) : '0;
    last_pick = pick;
    @(posedge clk);
    m_cyc++;
    if (pop) void'(m_fifo.pop_front());
    while (m_infl.size() != 0 && m_infl[0].due == m_cyc) m_fifo.push_back(m_infl.pop_front());
    if (pick >= 0) begin
      m_infl.push_back('{pick, sum, m_cyc + LAT + 2});
      if (!(PRIO && pick == 0)) m_ptr = (pick + 1) % N;
    end
    m_start = (pick >= 0);
    if (m_fifo.size() > DEPTH) ovf++;
    #1;
  endtask

  task automatic check_rst(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 32'(0));
    chk({tag, "_add_start"}, 32'(add_start), 32'(0));
    chk({tag, "_add_a"}, 32'(add_a), 32'(0));
    chk({tag, "_add_b"}, 32'(add_b), 32'(0));
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(0));
    chk({tag, "_rsp_id"}, 32'(rsp_id), 32'(0));
    chk({tag, "_rsp_y"}, 32'(rsp_y), 32'(0));
    chk({tag, "_busy"}, 32'(busy), 32'(0));
  endtask

  task automatic apply_reset();
    req = '0;
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    req = '0;
    rsp_ready = 1'b1;
    repeat (LAT + DEPTH + 4) cycle();
  endtask

  task automatic single(input string tag, input int idx, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_y);
    int k;
    req = '0;
    rsp_ready = 1'b1;
    req[idx] = 1'b1;
    req_a[idx*W +: W] = a;
    req_b[idx*W +: W] = b;
    cycle();
    chk({tag, "_gnt"}, 32'(s_gnt), 32'(1 << idx));
    req = '0;
    for (k = 1; k <= 12; k++) begin
      cycle();
      if (s_valid) break;
    end
    chk({tag, "_latency"}, 32'(k - 1), 32'(4));
    chk({tag, "_id"}, 32'(s_id), 32'(idx));
    chk({tag, "_y"}, 32'(s_y), 32'(exp_y));
    cycle();
    cycle();
    chk({tag, "_busy_after_pop"}, 32'(s_busy), 32'(0));
  endtask

  task automatic drive_random();
    for (int i = 0; i < N; i++) begin
      if (req[i] && last_pick != i) begin
        if ($urandom_range(0, 15) == 0) req[i] = 1'b0;
      end else begin
        req[i] = ($urandom_range(0, 2) != 0);
        req_a[i*W +: W] = rnd_op();
        req_b[i*W +: W] = rnd_op();
      end
    end
    rsp_ready = ($urandom_range(0, 9) < 7);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int got;
    int cnt;
    int idx;
    int g0;
    int g1;
    int k;
    n_chk = 0; n_pass = 0; ovf = 0; m_cyc = 0;
    model_reset();
    rst_n = 1'b0; req = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_rst("init");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    single("single", 2, 8'h12, 8'h34, 8'h46);
    single("wrap", 1, 8'hFF, 8'h02, 8'h01);

    // Fairness from a fresh pointer.
    apply_reset();
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = rnd_op();
      req_b[i*W +: W] = rnd_op();
    end
    req = '1;
    rsp_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      cycle();
      if (s_gnt != '0) begin
        idx = onehot_idx(s_gnt);
        chk("fair_order", 32'(idx), PRIO ? 32'(0) : 32'(got % N));
        got++;
        req_a[idx*W +: W] = rnd_op();
        req_b[idx*W +: W] = rnd_op();
      end
    end
    chk("fair_count", 32'(got), 32'(8));
    drain();

    // Backpressure: exactly DEPTH accepts with the consumer stalled.
    req = '1;
    rsp_ready = 1'b0;
    cnt = 0;
    repeat (12) begin
      cycle();
      if (s_gnt != '0) begin
        idx = onehot_idx(s_gnt);
        cnt++;
        req_a[idx*W +: W] = rnd_op();
        req_b[idx*W +: W] = rnd_op();
      end
    end
    chk("bp_accepts", 32'(cnt), 32'(DEPTH));
    chk("bp_gnt_idle", 32'(s_gnt), 32'(0));
    rsp_ready = 1'b1;
    repeat (8) cycle();
    drain();

    // Reset with three operations in flight.
    req = '1;
    rsp_ready = 1'b0;
    repeat (3) cycle();
    req = '0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_rst("midrst");
    repeat (2) @(posedge clk);
    #1;
    check_rst("midrst_hold");
    @(negedge clk) rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    cnt = 0;
    repeat (8) begin
      cycle();
      if (s_valid) cnt++;
    end
    chk("midrst_no_stale", 32'(cnt), 32'(0));
    req = '1;
    cycle();
    chk("midrst_first_gnt", 32'(s_gnt), 32'(1));
    drain();

    // Randomized traffic.
    repeat (400) begin
      drive_random();
      cycle();
    end
    drain();

`ifdef ADD_SHARE_ARB_PRIO0_EN
    req = 4'b0011;
    rsp_ready = 1'b1;
    g0 = 0;
    g1 = 0;
    repeat (12) begin
      cycle();
      if (s_gnt == 4'b0001) g0++;
      if (s_gnt == 4'b0010) g1++;
    end
    chk("prio_starve1", 32'(g1), 32'(0));
    chk("prio_gnt0_seen", 32'(g0 > 0), 32'(1));
    req = 4'b0010;
    for (k = 0; k < 8; k++) begin
      cycle();
      if (s_gnt != '0) break;
    end
    chk("prio_drop0_gnt1", 32'(s_gnt), 32'(2));
    drain();
`else
    g0 = 0;
    g1 = 0;
    k = 0;
`endif

    chk("no_overflow", 32'(ovf), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
